// File: rtl/benes_ctrl_loader.sv
`default_nettype none
// ============================================================================
// Module      : benes_ctrl_loader
// Description : Assembles the Benes network control word from config beats,
//               swaps it in only when the network is empty, gates data issue.
// Revision    : 1.0 - initial release
// ============================================================================
module benes_ctrl_loader #(
    parameter int          SIZE          = 32,
    parameter int          DWIDTH        = 16,
    parameter logic [63:0] REGISTER_MASK = 64'hFF,
    parameter int          CHUNK         = 32
) (
    input  logic                                          clk,
    input  logic                                          n_rst,
    input  logic                                          cfg_valid,
    output logic                                          cfg_ready,
    input  logic [CHUNK-1:0]                              cfg_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic [(2*$clog2(SIZE)-1)*(SIZE/2)-1:0]        control_bit,
    output logic                                          out_valid,
    output logic                                          cfg_loaded,
    output logic                                          swap_done
);

    function automatic int popcount_mask(input logic [63:0] m, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            c += int'(m[i]);
        end
        return c;
    endfunction

    localparam int TAGWIDTH = $clog2(SIZE);
    localparam int STAGES   = 2 * TAGWIDTH - 1;
    localparam int BITWIDTH = STAGES * (SIZE / 2);
    localparam int BEATS    = (BITWIDTH + CHUNK - 1) / CHUNK;
    localparam int LATENCY  = popcount_mask(REGISTER_MASK, STAGES - 1);
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (SIZE < 4 || (SIZE & (SIZE - 1)) != 0 || DWIDTH < 1) begin : g_bad_params
        $error("benes_ctrl_loader: SIZE must be a power of two >= 4 and DWIDTH >= 1");
    end

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [BITWIDTH-1:0]   r_shadow;
    logic [BITWIDTH-1:0]   r_active;
    logic                  r_cfg_loaded;
    logic                  r_swap_done;
    logic                  w_cfg_fire;
    logic                  w_last_beat;
    logic                  w_swap;
    logic                  w_issue;
    logic                  w_pipe_empty;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cfg_ready    = 1'b0;
        w_cfg_fire   = 1'b0;
        w_last_beat  = 1'b0;
        w_swap       = 1'b0;
        case (r_state)
            S_LOAD: begin
                cfg_ready   = 1'b1;
                w_cfg_fire  = cfg_valid;
                w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));
                if (cfg_valid && w_last_beat) begin
                    w_state_next = S_PEND;
                end
            end
            S_PEND: begin
                // Swap only once every issued vector has left the network.
                if (w_pipe_empty) begin
                    w_swap       = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            default: w_state_next = S_LOAD;
        endcase
    end

    assign in_ready = (r_state == S_LOAD) && r_cfg_loaded;
    assign w_issue  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_beat_cnt   <= '0;
            r_shadow     <= '0;
            r_active     <= '0;
            r_cfg_loaded <= 1'b0;
            r_swap_done  <= 1'b0;
        end else begin
            r_swap_done <= w_swap;
            if (w_cfg_fire) begin
                // Bits of the final beat beyond the control word are dropped.
                for (int i = 0; i < CHUNK; i++) begin
                    if (int'(r_beat_cnt) * CHUNK + i < BITWIDTH) begin
                        r_shadow[int'(r_beat_cnt) * CHUNK + i] <= cfg_data[i];
                    end
                end
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
            end
            if (w_swap) begin
                r_active     <= r_shadow;
                r_cfg_loaded <= 1'b1;
            end
        end
    end

    if (LATENCY == 0) begin : g_no_pipe
        assign w_pipe_empty = 1'b1;
        assign out_valid    = w_issue;
    end else begin : g_pipe
        logic [LATENCY-1:0] r_vpipe;

        always_ff @(posedge clk) begin
            if (n_rst) begin
                r_vpipe <= '0;
            end else begin
                r_vpipe[0] <= w_issue;
                for (int i = 1; i < LATENCY; i++) begin
                    r_vpipe[i] <= r_vpipe[i-1];
                end
            end
        end

        assign w_pipe_empty = (r_vpipe == '0);
        assign out_valid    = r_vpipe[LATENCY-1];
    end

    assign control_bit = r_active;
    assign cfg_loaded  = r_cfg_loaded;
    assign swap_done   = r_swap_done;

endmodule
`default_nettype wire

// File: tb/tb_benes_ctrl_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_benes_ctrl_loader
// Description : Scoreboard bench for benes_ctrl_loader (default and zero-latency masks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_benes_ctrl_loader;

    localparam int BW  = 144;
    localparam int CH  = 32;
    localparam int NB  = 5;
    localparam int LAT = 8;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          cfg_valid, cfg_valid_z;
    logic [CH-1:0] cfg_data, cfg_data_z;
    logic          in_valid, in_valid_z;
    logic          cfg_ready, cfg_ready_z;
    logic          in_ready, in_ready_z;
    logic [BW-1:0] control_bit, control_bit_z;
    logic          out_valid, out_valid_z;
    logic          cfg_loaded, cfg_loaded_z;
    logic          swap_done, swap_done_z;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            q[$];
    bit            mon_en = 1'b0;
    logic [CH-1:0] beats[NB];
    logic [BW-1:0] active_exp;
    logic [BW-1:0] new_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    benes_ctrl_loader dut (
        .clk(clk), .n_rst(n_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready),
        .control_bit(control_bit), .out_valid(out_valid),
        .cfg_loaded(cfg_loaded), .swap_done(swap_done)
    );

    benes_ctrl_loader #(.REGISTER_MASK(64'h0)) dut_z (
        .clk(clk), .n_rst(n_rst), .cfg_valid(cfg_valid_z), .cfg_ready(cfg_ready_z),
        .cfg_data(cfg_data_z), .in_valid(in_valid_z), .in_ready(in_ready_z),
        .control_bit(control_bit_z), .out_valid(out_valid_z),
        .cfg_loaded(cfg_loaded_z), .swap_done(swap_done_z)
    );

    // Scoreboard: every issue pushes the cycle its out_valid is due.
    always @(negedge clk) begin
        if (mon_en) begin
            bit e;
            e = (q.size() > 0) && (q[0] == cyc);
            if (e) void'(q.pop_front());
            checks++;
            if (out_valid !== e) begin
                errors++;
                $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [BW-1:0] pack_beats();
        logic [NB*CH-1:0] t;
        for (int k = 0; k < NB; k++) t[k*CH +: CH] = beats[k];
        return t[BW-1:0];
    endfunction

    task automatic test_reset();
        n_rst = 1'b1;
        cfg_valid = 1'b0; cfg_data = '0; in_valid = 1'b0;
        cfg_valid_z = 1'b0; cfg_data_z = '0; in_valid_z = 1'b0;
        repeat (2) tick();
        mon_en = 1'b1;
        tick();
        n_rst = 1'b0;
        sample();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (control_bit !== '0) begin errors++; $display("FAIL reset_control_bit got=%h exp=0", control_bit); end
        checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("FAIL reset_cfg_loaded got=%b exp=0", cfg_loaded); end
        checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL reset_swap_done got=%b exp=0", swap_done); end
        active_exp = '0;
    endtask

    task automatic test_load();
        beats[0] = 32'h11111111; beats[1] = 32'h22222222; beats[2] = 32'h33333333;
        beats[3] = 32'h44444444; beats[4] = 32'h55555555;
        for (int k = 0; k < NB; k++) begin
            tick();
            cfg_valid = 1'b1; cfg_data = beats[k];
            sample();
            checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL load_cfg_ready beat=%0d got=%b exp=1", k, cfg_ready); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_in_ready beat=%0d got=%b exp=0", k, in_ready); end
        end
        tick();
        cfg_valid = 1'b0;
        sample();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL pend_cfg_ready got=%b exp=0", cfg_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pend_in_ready got=%b exp=0", in_ready); end
        tick();
        sample();
        new_exp = 144'h5555_44444444_33333333_22222222_11111111;
        checks++; if (control_bit !== new_exp) begin errors++; $display("FAIL load_control_bit got=%h exp=%h", control_bit, new_exp); end
        checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL load_swap_done got=%b exp=1", swap_done); end
        checks++; if (cfg_loaded !== 1'b1) begin errors++; $display("FAIL load_cfg_loaded got=%b exp=1", cfg_loaded); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready_after got=%b exp=1", in_ready); end
        active_exp = new_exp;
        tick();
        sample();
        checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL swap_done_pulse got=%b exp=0", swap_done); end
    endtask

    task automatic test_single_issue();
        for (int n = 0; n < 2; n++) begin
            tick();
            in_valid = 1'b1;
            sample();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL issue_in_ready n=%0d got=%b exp=1", n, in_ready); end
            q.push_back(cyc + LAT);
            tick();
            in_valid = 1'b0;
            tick();
        end
        repeat (12) tick();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL issue_drain got=%0d pending exp=0", q.size()); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NB; k++) beats[k] = $urandom;
        new_exp = pack_beats();
        for (int k = 0; k < NB; k++) begin
            tick();
            cfg_valid = 1'b1; cfg_data = beats[k]; in_valid = 1'b1;
            sample();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready beat=%0d got=%b exp=1", k, in_ready); end
            checks++; if (control_bit !== active_exp) begin errors++; $display("FAIL b2b_ctrl_hold beat=%0d got=%h exp=%h", k, control_bit, active_exp); end
            q.push_back(cyc + LAT);
        end
        for (int j = 1; j <= 9; j++) begin
            tick();
            cfg_valid = 1'b0;
            sample();
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_pend_in_ready t+%0d got=%b exp=0", j, in_ready); end
            checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_pend_cfg_ready t+%0d got=%b exp=0", j, cfg_ready); end
            checks++; if (control_bit !== active_exp) begin errors++; $display("FAIL b2b_pend_ctrl t+%0d got=%h exp=%h", j, control_bit, active_exp); end
            checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL b2b_pend_swap t+%0d got=%b exp=0", j, swap_done); end
        end
        tick();
        in_valid = 1'b0;
        sample();
        checks++; if (control_bit !== new_exp) begin errors++; $display("FAIL b2b_new_ctrl got=%h exp=%h", control_bit, new_exp); end
        checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL b2b_swap_done got=%b exp=1", swap_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_after got=%b exp=1", in_ready); end
        active_exp = new_exp;
        repeat (10) tick();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_drain got=%0d pending exp=0", q.size()); end
    endtask

    task automatic test_alternate();
        for (int k = 0; k < NB; k++) beats[k] = $urandom;
        new_exp = pack_beats();
        for (int i = 0; i < 10; i++) begin
            tick();
            cfg_valid = (i % 2 == 0) && (i < 9);
            cfg_data  = cfg_valid ? beats[i/2] : $urandom;
            sample();
            if (i < 9) begin
                checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL alt_cfg_ready i=%0d got=%b exp=1", i, cfg_ready); end
            end else begin
                checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL alt_pend i=%0d got=%b exp=0", i, cfg_ready); end
            end
        end
        tick();
        cfg_valid = 1'b0;
        sample();
        checks++; if (control_bit !== new_exp) begin errors++; $display("FAIL alt_ctrl got=%h exp=%h", control_bit, new_exp); end
        checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL alt_swap_done got=%b exp=1", swap_done); end
        active_exp = new_exp;
        tick();
    endtask

    task automatic test_reset_midload();
        for (int k = 0; k < 3; k++) begin
            tick();
            cfg_valid = 1'b1; cfg_data = $urandom;
        end
        tick();
        cfg_valid = 1'b0; n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        sample();
        checks++; if (control_bit !== '0) begin errors++; $display("FAIL rst_mid_ctrl got=%h exp=0", control_bit); end
        checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("FAIL rst_mid_cfg_loaded got=%b exp=0", cfg_loaded); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=0", in_ready); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_cfg_ready got=%b exp=1", cfg_ready); end
        active_exp = '0;
        for (int k = 0; k < NB; k++) beats[k] = $urandom;
        new_exp = pack_beats();
        for (int k = 0; k < NB; k++) begin
            tick();
            cfg_valid = 1'b1; cfg_data = beats[k];
            sample();
            checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_reload_cfg_ready beat=%0d got=%b exp=1", k, cfg_ready); end
        end
        tick();
        cfg_valid = 1'b0;
        sample();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_reload_pend got=%b exp=0", cfg_ready); end
        tick();
        sample();
        checks++; if (control_bit !== new_exp) begin errors++; $display("FAIL rst_reload_ctrl got=%h exp=%h", control_bit, new_exp); end
        checks++; if (cfg_loaded !== 1'b1) begin errors++; $display("FAIL rst_reload_loaded got=%b exp=1", cfg_loaded); end
        active_exp = new_exp;
    endtask

    task automatic test_lat0();
        tick();
        in_valid_z = 1'b1;
        sample();
        checks++; if (in_ready_z !== 1'b0) begin errors++; $display("FAIL lat0_unloaded_in_ready got=%b exp=0", in_ready_z); end
        checks++; if (out_valid_z !== 1'b0) begin errors++; $display("FAIL lat0_unloaded_out_valid got=%b exp=0", out_valid_z); end
        for (int k = 0; k < NB; k++) beats[k] = $urandom;
        new_exp = pack_beats();
        for (int k = 0; k < NB; k++) begin
            tick();
            cfg_valid_z = 1'b1; cfg_data_z = beats[k];
        end
        tick();
        cfg_valid_z = 1'b0;
        sample();
        checks++; if (cfg_ready_z !== 1'b0) begin errors++; $display("FAIL lat0_pend got=%b exp=0", cfg_ready_z); end
        checks++; if (out_valid_z !== 1'b0) begin errors++; $display("FAIL lat0_pend_out_valid got=%b exp=0", out_valid_z); end
        tick();
        sample();
        checks++; if (swap_done_z !== 1'b1) begin errors++; $display("FAIL lat0_swap_done got=%b exp=1", swap_done_z); end
        checks++; if (control_bit_z !== new_exp) begin errors++; $display("FAIL lat0_ctrl got=%h exp=%h", control_bit_z, new_exp); end
        checks++; if (in_ready_z !== 1'b1) begin errors++; $display("FAIL lat0_in_ready got=%b exp=1", in_ready_z); end
        checks++; if (out_valid_z !== 1'b1) begin errors++; $display("FAIL lat0_out_valid got=%b exp=1", out_valid_z); end
        tick();
        in_valid_z = 1'b0;
        sample();
        checks++; if (out_valid_z !== 1'b0) begin errors++; $display("FAIL lat0_out_valid_idle got=%b exp=0", out_valid_z); end
        checks++; if (in_ready_z !== 1'b1) begin errors++; $display("FAIL lat0_in_ready_idle got=%b exp=1", in_ready_z); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_single_issue();
        test_back_to_back();
        test_alternate();
        test_reset_midload();
        test_lat0();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
